// File: rtl/snake_move_ctrl_if.sv
// rtl/snake_move_ctrl_if.sv - keyboard and renderer read-port bundle for snake_move_ctrl
//
// Purpose: groups the key strobe and the segment read port.
// Ports:
//   key_code/key_valid  keyboard code and its one-cycle qualifier
//   rd_idx              segment index requested by the renderer (0 = head)
//   rd_x/rd_y/rd_valid  registered read data for rd_idx
// Modports: master = keyboard/renderer side, slave = snake_move_ctrl.
interface snake_move_ctrl_if #(
  parameter int IW = 6
);
  logic [7:0]    key_code;
  logic          key_valid;
  logic [IW-1:0] rd_idx;
  logic [5:0]    rd_x;
  logic [5:0]    rd_y;
  logic          rd_valid;

  modport master (
    output key_code, key_valid, rd_idx,
    input  rd_x, rd_y, rd_valid
  );

  modport slave (
    input  key_code, key_valid, rd_idx,
    output rd_x, rd_y, rd_valid
  );
endinterface

// File: rtl/snake_move_ctrl.sv
// rtl/snake_move_ctrl.sv - snake body store and movement tick sequencer
//
// Purpose: keeps the snake segments in a circular buffer, advances the head one
// cell per movement tick, filters direction keys and checks wall/self collisions.
// Ports:
//   CLOCK_50, RESET_N     clock, asynchronous active-low reset
//   bus (slave)           key input and registered segment read port
//   pause                 freezes the tick counter
//   food_x, food_y        current food cell
//   head_x, head_y        current head cell
//   length                segment count, 1..MAX_LEN
//   food_eaten            one-cycle pulse on a commit onto food
//   game_over             sticky until reset
//   busy                  a move is being evaluated
module snake_move_ctrl #(
  parameter int MAX_LEN  = 64,
  parameter int GRID     = 50,
  parameter int TICK_DIV = 5_000_000,
  parameter int START_X  = 25,
  parameter int START_Y  = 25
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_N,
  snake_move_ctrl_if.slave         bus,
  input  logic                     pause,
  input  logic [5:0]               food_x,
  input  logic [5:0]               food_y,
  output logic [5:0]               head_x,
  output logic [5:0]               head_y,
  output logic [$clog2(MAX_LEN):0] length,
  output logic                     food_eaten,
  output logic                     game_over,
  output logic                     busy
);
  localparam int IW = $clog2(MAX_LEN);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [IW:0]   MAX_L      = (IW+1)'(MAX_LEN);
  localparam logic [IW:0]   ONE_L      = (IW+1)'(1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [5:0]    EDGE       = 6'(GRID - 1);
  localparam logic [11:0]   START_CELL = {6'(START_X), 6'(START_Y)};

  typedef enum logic [2:0] {S_IDLE, S_NEXT, S_SCAN, S_COMMIT, S_OVER} state_t;
  state_t state, state_nx;

  logic [11:0]   body [MAX_LEN];
  logic [IW-1:0] hp, k, scan_idx, rd_ptr, hp_inc;
  logic [IW:0]   len_r;
  logic [1:0]    cur_dir, pending_dir, dir;
  logic [5:0]    nx, ny, cx, cy;
  logic          grow, wall, tick_pend, tick_clr, tick_term;
  logic [TW-1:0] tick_cnt;
  logic          key_ok, scan_last, scan_skip, scan_hit;
  logic [1:0]    key_dir;

  assign head_x    = body[hp][11:6];
  assign head_y    = body[hp][5:0];
  assign length    = len_r;
  assign game_over = (state == S_OVER);
  assign busy      = (state != S_IDLE) && (state != S_OVER);
  assign hp_inc    = hp + IW'(1);
  assign rd_ptr    = hp - bus.rd_idx;
  assign tick_term = !pause && (state != S_OVER) && (tick_cnt == TICK_LAST);

  // Candidate head cell; the wall test looks at the current head so the
  // 6-bit step never wraps into the store.
  always_comb begin
    cx   = head_x;
    cy   = head_y;
    wall = 1'b0;
    case (pending_dir)
      2'b00: begin wall = (head_y == 6'd0); cy = head_y - 6'd1; end
      2'b01: begin wall = (head_x == EDGE); cx = head_x + 6'd1; end
      2'b11: begin wall = (head_y == EDGE); cy = head_y + 6'd1; end
      default: begin wall = (head_x == 6'd0); cx = head_x - 6'd1; end
    endcase
  end

  always_comb begin
    key_ok  = 1'b1;
    key_dir = 2'b00;
    case (bus.key_code)
      8'd117: key_dir = 2'b00;
      8'd116: key_dir = 2'b01;
      8'd114: key_dir = 2'b11;
      8'd107: key_dir = 2'b10;
      default: key_ok = 1'b0;
    endcase
  end

  // The tail cell vacates on a non-growing move, and also when full since
  // growth is capped and the oldest entry is overwritten.
  assign scan_idx  = hp - k;
  assign scan_last = ({1'b0, k} == (len_r - ONE_L));
  assign scan_skip = scan_last && (!grow || (len_r == MAX_L));
  assign scan_hit  = (body[scan_idx] == {nx, ny}) && !scan_skip;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tick_clr = 1'b0;
    case (state)
      S_IDLE: if (tick_pend) begin
        tick_clr = 1'b1;
        state_nx = S_NEXT;
      end
      S_NEXT:   state_nx = wall ? S_OVER : S_SCAN;
      S_SCAN: begin
        if (scan_hit)       state_nx = S_OVER;
        else if (scan_last) state_nx = S_COMMIT;
      end
      S_COMMIT: state_nx = S_IDLE;
      S_OVER:   state_nx = S_OVER;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < MAX_LEN; i++) body[i] <= (i == 0) ? START_CELL : 12'd0;
      hp           <= '0;
      len_r        <= ONE_L;
      cur_dir      <= 2'b00;
      pending_dir  <= 2'b00;
      dir          <= 2'b00;
      nx           <= '0;
      ny           <= '0;
      grow         <= 1'b0;
      k            <= '0;
      tick_cnt     <= '0;
      tick_pend    <= 1'b0;
      food_eaten   <= 1'b0;
      bus.rd_x     <= '0;
      bus.rd_y     <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      if (!pause && state != S_OVER)
        tick_cnt <= tick_term ? '0 : tick_cnt + TW'(1);
      // A tick landing on the clear cycle still counts as pending.
      if (tick_term)     tick_pend <= 1'b1;
      else if (tick_clr) tick_pend <= 1'b0;

      if (bus.key_valid && key_ok && state != S_OVER && key_dir != ~cur_dir)
        pending_dir <= key_dir;

      if (state == S_NEXT) begin
        dir  <= pending_dir;
        nx   <= cx;
        ny   <= cy;
        grow <= ({cx, cy} == {food_x, food_y});
        k    <= '0;
      end
      if (state == S_SCAN) k <= k + IW'(1);
      if (state == S_COMMIT) begin
        hp           <= hp_inc;
        body[hp_inc] <= {nx, ny};
        cur_dir      <= dir;
        if (grow && len_r != MAX_L) len_r <= len_r + ONE_L;
      end
      food_eaten <= (state == S_COMMIT) && grow;

      bus.rd_x     <= body[rd_ptr][11:6];
      bus.rd_y     <= body[rd_ptr][5:0];
      bus.rd_valid <= ({1'b0, bus.rd_idx} < len_r);
    end
  end
endmodule

// File: tb/tb_snake_move_ctrl.sv
// tb/tb_snake_move_ctrl.sv - directed self-checking bench for snake_move_ctrl
module tb_snake_move_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pause = 1'b0;
  logic [5:0] food_x, food_y, head_x, head_y;
  logic [6:0] length;
  logic       food_eaten, game_over, busy;

  int n_total = 0;
  int n_pass  = 0;
  int fe_cnt;
  logic [5:0] rd_cx, rd_cy, rd_nx, rd_ny;
  logic       busy_seen;

  always #5 clk = ~clk;

  snake_move_ctrl_if #(.IW(6)) bus ();

  snake_move_ctrl #(
    .MAX_LEN(64), .GRID(50), .TICK_DIV(100), .START_X(25), .START_Y(25)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .bus(bus), .pause(pause),
    .food_x(food_x), .food_y(food_y), .head_x(head_x), .head_y(head_y),
    .length(length), .food_eaten(food_eaten), .game_over(game_over), .busy(busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic expect_head(input string tag, input int x, input int y);
    check({tag, "_x"}, head_x, x);
    check({tag, "_y"}, head_y, y);
  endtask

  task automatic key(input logic [7:0] code);
    @(negedge clk);
    bus.key_code  = code;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for one move to start and finish; records food pulses and the
  // head read port (rd_idx=0) in the two cycles after the commit edge.
  task automatic wait_move(input string tag);
    int c;
    fe_cnt = 0;
    c = 0;
    while (!busy && c < 400) begin @(negedge clk); c++; end
    check({tag, "_start"}, busy, 1);
    c = 0;
    while (busy && c < 200) begin @(negedge clk); c++; end
    check({tag, "_done"}, busy, 0);
    rd_cx = bus.rd_x; rd_cy = bus.rd_y; fe_cnt += int'(food_eaten);
    @(negedge clk);
    rd_nx = bus.rd_x; rd_ny = bus.rd_y; fe_cnt += int'(food_eaten);
  endtask

  task automatic step(input string tag, input int x, input int y);
    wait_move(tag);
    expect_head(tag, x, y);
  endtask

  task automatic wait_busy(input string tag);
    int c = 0;
    while (!busy && c < 400) begin @(negedge clk); c++; end
    check({tag, "_busy"}, busy, 1);
  endtask

  initial begin
    bus.key_code = 8'd0; bus.key_valid = 1'b0; bus.rd_idx = '0;
    food_x = 6'd0; food_y = 6'd49;
    repeat (2) @(negedge clk);
    expect_head("rst_head", 25, 25);
    check("rst_len", length, 1);
    check("rst_over", game_over, 0);
    check("rst_busy", busy, 0);
    check("rst_food", food_eaten, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_x", bus.rd_x, 0);
    rst_n = 1'b1;

    // Straight up, no keys; head read port lags the commit by one cycle.
    step("up1", 25, 24);
    check("rd_old_x", rd_cx, 25); check("rd_old_y", rd_cy, 25);
    check("rd_new_x", rd_nx, 25); check("rd_new_y", rd_ny, 24);
    step("up2", 25, 23);
    step("up3", 25, 22);
    check("up_len", length, 1);
    check("up_over", game_over, 0);

    // Left accepted, then right (reversal) rejected.
    key(8'd107);
    step("left", 24, 22);
    key(8'd116);
    step("rev", 23, 22);

    // Eat the food directly ahead.
    food_x = 6'd22; food_y = 6'd22;
    step("eat", 22, 22);
    food_x = 6'd0; food_y = 6'd49;
    check("eat_pulse", fe_cnt, 1);
    check("eat_len", length, 2);
    bus.rd_idx = 6'd1;
    @(negedge clk);
    check("rd1_x", bus.rd_x, 23); check("rd1_y", bus.rd_y, 22);
    check("rd1_valid", bus.rd_valid, 1);
    bus.rd_idx = 6'd2;
    @(negedge clk);
    check("rd2_valid", bus.rd_valid, 0);
    bus.rd_idx = 6'd0;

    // Climb to the top wall and hit it.
    key(8'd117);
    for (int y = 21; y >= 0; y--) step("climb", 22, y);
    wait_move("wall");
    check("wall_over", game_over, 1);
    expect_head("wall_head", 22, 0);
    repeat (250) @(negedge clk);
    key(8'd107);
    repeat (250) @(negedge clk);
    expect_head("over_frozen", 22, 0);
    check("over_len", length, 2);
    check("over_sticky", game_over, 1);
    check("over_busy", busy, 0);
    do_reset();
    expect_head("rst2_head", 25, 25);
    check("rst2_len", length, 1);
    check("rst2_over", game_over, 0);

    // Grow to 5 and loop back into the body.
    for (int i = 1; i <= 4; i++) begin
      food_x = 6'd25; food_y = 6'(25 - i);
      step("grow", 25, 25 - i);
    end
    food_x = 6'd0; food_y = 6'd49;
    check("grow_len", length, 5);
    key(8'd116); step("u_r", 26, 21);
    key(8'd114); step("u_d", 26, 22);
    key(8'd107); wait_move("bite");
    check("bite_over", game_over, 1);
    expect_head("bite_head", 26, 22);

    // Same loop at length 4 enters the vacating tail cell.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      food_x = 6'd25; food_y = 6'(25 - i);
      step("grow4", 25, 25 - i);
    end
    food_x = 6'd0; food_y = 6'd49;
    check("grow4_len", length, 4);
    key(8'd116); step("t_r", 26, 22);
    key(8'd114); step("t_d", 26, 23);
    key(8'd107); step("tail", 25, 23);
    check("tail_over", game_over, 0);
    check("tail_len", length, 4);

    // Pause for two tick periods: nothing moves.
    @(negedge clk);
    pause = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 210; i++) begin @(negedge clk); busy_seen |= busy; end
    check("pause_busy", busy_seen, 0);
    expect_head("pause_head", 25, 23);
    pause = 1'b0;

    // Pause raised mid-SCAN: the move still commits.
    wait_busy("pscan");
    @(negedge clk);
    @(negedge clk);
    pause = 1'b1;
    for (int c = 0; c < 200 && busy; c++) @(negedge clk);
    check("pscan_done", busy, 0);
    expect_head("pscan_head", 24, 23);
    pause = 1'b0;

    // Key during NEXT applies to the following move only.
    wait_busy("knext");
    bus.key_code = 8'd117; bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    for (int c = 0; c < 200 && busy; c++) @(negedge clk);
    expect_head("knext_cur", 23, 23);
    step("knext_nxt", 23, 22);

    // Reset mid-move aborts to start values.
    wait_busy("rmid");
    rst_n = 1'b0;
    #1;
    check("rmid_busy", busy, 0);
    expect_head("rmid_head", 25, 25);
    check("rmid_len", length, 1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
